// File: rtl/demux_reg_pkg.sv
// rtl/demux_reg_pkg.sv - shared types and constants for the registered demux
// Slot occupancy encoding and the default data width used by demux_reg and demux_slot.
package demux_reg_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  localparam int unsigned DEMUX_SIZE_DEFAULT = 1;

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output slot with load/deliver handshake
// Holds one word; a load and a delivery on the same edge keep the slot full with the new word.
module demux_slot
  import demux_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_SIZE_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             can_load_o
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load_i) begin
      state_d = SLOT_FULL;
      data_d  = data_i;
    end else if (state_q == SLOT_FULL && ready_i) begin
      // Data is kept after delivery; only occupancy changes.
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign data_o     = data_q;
  assign valid_o    = (state_q == SLOT_FULL);
  assign can_load_o = (state_q == SLOT_EMPTY) || ready_i;

endmodule

// File: rtl/demux_reg.sv
// rtl/demux_reg.sv - registered 1-to-2 demux with per-channel one-entry slots
// Decodes SEL, generates IN_READY and tracks a sticky flag for offers made with an unknown SEL.
module demux_reg
  import demux_reg_pkg::*;
#(
  parameter int unsigned DEMUX_SIZE = DEMUX_SIZE_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DEMUX_SIZE-1:0] in_i,
  input  logic                  in_valid_i,
  input  logic                  sel_i,
  output logic                  in_ready_o,
  output logic [DEMUX_SIZE-1:0] a_o,
  output logic                  a_valid_o,
  input  logic                  a_ready_i,
  output logic [DEMUX_SIZE-1:0] b_o,
  output logic                  b_valid_o,
  input  logic                  b_ready_i,
  output logic                  sel_err_o
);

  logic sel_a, sel_b, sel_bad;
  logic a_can_load, b_can_load;
  logic load_a, load_b;
  logic sel_err_q, sel_err_d;

  // An X/Z select falls through both equality tests and lands in sel_bad.
  always_comb begin
    sel_a   = 1'b0;
    sel_b   = 1'b0;
    sel_bad = 1'b0;
    if (sel_i == 1'b0) begin
      sel_a = 1'b1;
    end else if (sel_i == 1'b1) begin
      sel_b = 1'b1;
    end else begin
      sel_bad = 1'b1;
    end
  end

  assign in_ready_o = (sel_a && a_can_load) || (sel_b && b_can_load);
  assign load_a     = in_valid_i && sel_a && a_can_load;
  assign load_b     = in_valid_i && sel_b && b_can_load;
  assign sel_err_d  = sel_err_q || (in_valid_i && sel_bad);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err_o = sel_err_q;

  demux_slot #(.WIDTH(DEMUX_SIZE)) u_slot_a (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (load_a),
    .data_i     (in_i),
    .ready_i    (a_ready_i),
    .data_o     (a_o),
    .valid_o    (a_valid_o),
    .can_load_o (a_can_load)
  );

  demux_slot #(.WIDTH(DEMUX_SIZE)) u_slot_b (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (load_b),
    .data_i     (in_i),
    .ready_i    (b_ready_i),
    .data_o     (b_o),
    .valid_o    (b_valid_o),
    .can_load_o (b_can_load)
  );

endmodule

// File: tb/tb_demux_reg.sv
// tb/tb_demux_reg.sv - self-checking bench for demux_reg with a queue-based reference model
// Directed corner cases followed by a randomized stream against per-channel expected-word queues.
module tb_demux_reg;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_d;
  logic         in_valid;
  logic         sel;
  logic         a_ready;
  logic         b_ready;
  logic         in_ready;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         a_valid;
  logic         b_valid;
  logic         sel_err;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  demux_reg #(.DEMUX_SIZE(W)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_i       (in_d),
    .in_valid_i (in_valid),
    .sel_i      (sel),
    .in_ready_o (in_ready),
    .a_o        (a_q),
    .a_valid_o  (a_valid),
    .a_ready_i  (a_ready),
    .b_o        (b_q),
    .b_valid_o  (b_valid),
    .b_ready_i  (b_ready),
    .sel_err_o  (sel_err)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] exp_q [2][$];
  logic [W-1:0] last_word [2];
  logic [W-1:0] dout [2];
  logic         rdy [2];
  logic         exp_rdy;
  logic         probe;
  logic [W-1:0] w;
  int           accepted;
  int           cycles;
  int           s;

  initial begin
    rst_n    = 1'b0;
    in_d     = '0;
    in_valid = 1'b0;
    sel      = 1'b0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    #2;
    check("rst_a_valid", a_valid, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_a", a_q, 0);
    check("rst_b", b_q, 0);
    check("rst_sel_err", sel_err, 0);
    check("rst_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_d     = 32'hCAFE_0000;
    tick();
    check("rst_no_load", a_valid, 0);
    in_valid = 1'b0;

    // Basic load into A
    rst_n    = 1'b1;
    in_d     = 32'hDEAD_BEEF;
    sel      = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("load_a", a_q, 32'hDEAD_BEEF);
    check("load_a_valid", a_valid, 1);
    check("load_b_valid", b_valid, 0);
    check("load_b", b_q, 0);

    // A full and stalled: offer to A is refused
    in_d     = 32'h0000_0077;
    in_valid = 1'b1;
    #1;
    check("stall_ready", in_ready, 0);
    tick();
    check("stall_a_hold", a_q, 32'hDEAD_BEEF);
    check("stall_a_valid", a_valid, 1);
    a_ready = 1'b1;
    in_d    = 32'h0000_0001;
    #1;
    check("pass_ready", in_ready, 1);
    tick();
    a_ready  = 1'b0;
    in_valid = 1'b0;
    check("pass_a", a_q, 32'h1);
    check("pass_a_valid", a_valid, 1);

    // A stalled, offer to B goes through
    sel      = 1'b1;
    in_d     = 32'h5;
    in_valid = 1'b1;
    #1;
    check("b_ready_in", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("b_load", b_q, 32'h5);
    check("b_valid", b_valid, 1);
    check("b_a_hold", a_q, 32'h1);
    check("b_a_valid", a_valid, 1);

    // Asynchronous reset between edges
    #1;
    rst_n = 1'b0;
    #1;
    check("async_a_valid", a_valid, 0);
    check("async_b_valid", b_valid, 0);
    check("async_a", a_q, 0);
    check("async_b", b_q, 0);
    check("async_sel_err", sel_err, 0);
    tick();
    rst_n = 1'b1;

    // Unknown SEL without an offer never flags
    sel      = 1'bx;
    in_valid = 1'b0;
    tick();
    check("selx_idle_err", sel_err, 0);

    probe = 1'bx;
    if ($isunknown(probe)) begin
      in_valid = 1'b1;
      in_d     = 32'h1234_5678;
      #1;
      check("selx_ready", in_ready, 0);
      tick();
      in_valid = 1'b0;
      check("selx_err", sel_err, 1);
      check("selx_a_valid", a_valid, 0);
      check("selx_b_valid", b_valid, 0);
      sel = 1'b0;
      tick();
      check("selx_sticky", sel_err, 1);
    end
    sel = 1'b0;

    // Randomized stream against per-channel queues
    #1;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    last_word[0] = '0;
    last_word[1] = '0;
    accepted = 0;
    cycles   = 0;
    while (accepted < 1000 && cycles < 20000) begin
      in_valid = 1'($urandom_range(0, 1));
      sel      = 1'($urandom_range(0, 1));
      a_ready  = 1'($urandom_range(0, 1));
      b_ready  = 1'($urandom_range(0, 1));
      in_d     = $urandom();
      #1;
      rdy[0]  = a_ready;
      rdy[1]  = b_ready;
      dout[0] = a_q;
      dout[1] = b_q;
      s       = int'(sel);
      exp_rdy = (exp_q[s].size() == 0) || rdy[s];
      check("rnd_in_ready", in_ready, exp_rdy);
      for (int ch = 0; ch < 2; ch++) begin
        if (exp_q[ch].size() != 0 && rdy[ch]) begin
          w = exp_q[ch].pop_front();
          check(ch == 0 ? "rnd_deliver_a" : "rnd_deliver_b", dout[ch], w);
        end
      end
      if (in_valid && exp_rdy) begin
        exp_q[s].push_back(in_d);
        last_word[s] = in_d;
        accepted++;
      end
      tick();
      cycles++;
      check("rnd_a_valid", a_valid, exp_q[0].size() != 0);
      check("rnd_b_valid", b_valid, exp_q[1].size() != 0);
      check("rnd_a", a_q, last_word[0]);
      check("rnd_b", b_q, last_word[1]);
    end
    check("rnd_accepted", accepted, 1000);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/demux_reg.md
DEMUX_REG -- requirements
Module: demux_reg

Interface
REQ-001 Parameter DEMUX_SIZE, default 1, data width in bits of IN, A and B.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 IN  input  DEMUX_SIZE  source data word.
REQ-005 IN_VALID  input  1  source offers IN this cycle.
REQ-006 SEL  input  1  destination select: 0 routes to A, 1 routes to B.
REQ-007 IN_READY  output  1  demux accepts IN this cycle.
REQ-008 A / B  output  DEMUX_SIZE each  registered destination data.
REQ-009 A_VALID / B_VALID  output  1 each  destination holds an undelivered word.
REQ-010 A_READY / B_READY  input  1 each  destination consumes its word this cycle.
REQ-011 SEL_ERR  output  1  sticky flag: an offer was made with SEL not 0 or 1.

Function
REQ-012 Each output channel SHALL be a one-entry slot with states EMPTY and FULL; x_VALID = 1 exactly when the slot is FULL.
REQ-013 Transfer into a channel SHALL occur on a rising edge where IN_VALID=1, IN_READY=1 and SEL selects that channel.
REQ-014 IN_READY SHALL be 1 when SEL=0 and (slot A EMPTY or A_READY=1), or SEL=1 and (slot B EMPTY or B_READY=1); otherwise 0.
REQ-015 Latency SHALL be one cycle: a word accepted at edge k appears on the selected output with x_VALID=1 immediately after edge k.
REQ-016 Delivery SHALL occur on a rising edge where x_VALID=1 and x_READY=1; with no new load the slot goes EMPTY.
REQ-017 Simultaneous delivery and load on the same channel SHALL leave the slot FULL holding the new word (no bubble, no loss).
REQ-018 The non-selected channel SHALL be unaffected by a transfer: its state, data and VALID are unchanged.
REQ-019 Output data SHALL hold the last loaded value while EMPTY; it is not cleared on delivery.
REQ-020 Data bits SHALL be passed unmodified; no width conversion, truncation or extension.
REQ-021 With SEL = X or Z: IN_READY SHALL be 0, no channel is loaded, and if IN_VALID=1 SEL_ERR SHALL be set on that edge.
REQ-022 SEL_ERR SHALL remain 1 until reset; IN_VALID=0 with unknown SEL SHALL NOT set it.
REQ-023 Both channels MAY deliver on the same edge, independently.
REQ-024 A word SHALL never be duplicated to both channels or dropped while FULL.

Reset
REQ-025 RST_N=0 SHALL immediately, without waiting for CLK, force both slots EMPTY, A=0, B=0, A_VALID=0, B_VALID=0, SEL_ERR=0.
REQ-026 IN_READY SHALL follow REQ-014 with both slots EMPTY during reset; no transfer SHALL complete while RST_N=0.
REQ-027 Reset asserted mid-operation SHALL discard held words; the first edge after deassertion behaves as from power-up.

Structure
REQ-028 The slot state enumeration (EMPTY, FULL) and the default width constant SHALL live in the shared project package.
REQ-029 The per-channel slot SHALL be a sub-module demux_slot (data register, state, load/deliver logic), instantiated twice.
REQ-030 demux_reg SHALL contain only select decode, IN_READY generation and SEL_ERR logic around the two slots.

Verification (DEMUX_SIZE=32)
REQ-031 Reset, then IN=32'hDEAD_BEEF, SEL=0, IN_VALID=1 one cycle, A_READY=0 -> A=32'hDEAD_BEEF, A_VALID=1, B_VALID=0, B=0.
REQ-032 A FULL, A_READY=0, offer SEL=0 -> IN_READY=0, A unchanged; raise A_READY with IN=32'h1 -> same edge delivers old word and loads 32'h1, A_VALID stays 1.
REQ-033 A FULL and stalled, offer SEL=1, IN=32'h5 -> IN_READY=1, B=32'h5, B_VALID=1, A unchanged.
REQ-034 SEL=1'bx with IN_VALID=1 -> IN_READY=0, no VALID change, SEL_ERR=1 after edge and stays 1; SEL=1'bx with IN_VALID=0 from reset -> SEL_ERR=0.
REQ-035 Both slots FULL, drop RST_N between edges -> A_VALID=B_VALID=0, A=B=0, SEL_ERR=0 immediately, before next CLK edge.
REQ-036 Random stream of 1000 words, random SEL and READY -> per-channel scoreboard shows every word delivered once, in order, on the selected channel only.
